// File: rtl/cdb_pkg.sv
// Shared CDB types and sizing.
// Lane bundle consumed by the RS, ROB and valid list.
package cdb_pkg;

    localparam int CDB_NUM_FU = 8;
    localparam int CDB_WAYS   = 4;
    localparam int XLEN       = 32;
    localparam int PRF        = 64;
    localparam int TW         = $clog2(PRF);

    typedef struct packed {
        logic            valid;
        logic [TW-1:0]   tag;
        logic [XLEN-1:0] value;
    } cdb_lane_t;

endpackage

// File: rtl/rr_multi_select.sv
// Rotating-priority selector granting up to K of N requests.
// Grants are packed into lanes in scan order starting at ptr.
module rr_multi_select #(
    parameter int N = 8,
    parameter int K = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         req,
    input  logic [PW-1:0]        ptr,
    output logic [N-1:0]         gnt,
    output logic [K-1:0]         lane_vld,
    output logic [K-1:0][PW-1:0] lane_idx,
    output logic [PW-1:0]        next_ptr
);

    logic [N-1:0]  rot;
    logic [N-1:0]  rem;
    logic          hit;
    logic [PW-1:0] pos;

    function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
        logic [PW:0] r;
        r = (v >= (PW+1)'(N)) ? v - (PW+1)'(N) : v;
        return r[PW-1:0];
    endfunction

    // Rotate so that bit 0 is the FU at ptr.
    always_comb begin
        rot = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = req[wrap({1'b0, PW'(j)} + {1'b0, ptr})];
        end
    end

    // K cascaded find-first-set passes, each un-rotated to an FU index.
    always_comb begin
        rem      = rot;
        gnt      = '0;
        lane_vld = '0;
        lane_idx = '0;
        next_ptr = ptr;
        hit      = 1'b0;
        pos      = '0;
        for (int k = 0; k < K; k++) begin
            hit = 1'b0;
            pos = '0;
            for (int j = N - 1; j >= 0; j--) begin
                if (rem[j]) begin
                    hit = 1'b1;
                    pos = PW'(j);
                end
            end
            if (hit) begin
                rem[pos]       = 1'b0;
                lane_vld[k]    = 1'b1;
                lane_idx[k]    = wrap({1'b0, pos} + {1'b0, ptr});
                gnt[lane_idx[k]] = 1'b1;
                next_ptr       = wrap({1'b0, lane_idx[k]} + (PW+1)'(1));
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to WAYS FU results per cycle.
// Broadcast is registered, one cycle after the grant.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU = CDB_NUM_FU,
    parameter int WAYS   = CDB_WAYS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        except,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU-1:0][TW-1:0]   fu_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0] fu_value,
    output logic [NUM_FU-1:0]           fu_ready,
    output logic [WAYS-1:0]             cdb_valid,
    output logic [WAYS-1:0][TW-1:0]     cdb_tag,
    output logic [WAYS-1:0][XLEN-1:0]   cdb_value
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           next_ptr;
    logic [NUM_FU-1:0]       gnt;
    logic [WAYS-1:0]         lane_vld;
    logic [WAYS-1:0][PW-1:0] lane_idx;
    cdb_lane_t               lane_q [WAYS];
    cdb_lane_t               lane_d [WAYS];

    rr_multi_select #(
        .N (NUM_FU),
        .K (WAYS)
    ) u_sel (
        .req      (fu_valid),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .lane_vld (lane_vld),
        .lane_idx (lane_idx),
        .next_ptr (next_ptr)
    );

    assign fu_ready = gnt & ~{NUM_FU{except}} & {NUM_FU{reset}};

    // Lane mux; idle lanes keep their last tag/value.
    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            lane_d[k]       = lane_q[k];
            lane_d[k].valid = 1'b0;
            if (!except && lane_vld[k]) begin
                lane_d[k].valid = 1'b1;
                lane_d[k].tag   = fu_tag[lane_idx[k]];
                lane_d[k].value = fu_value[lane_idx[k]];
            end
        end
    end

    // Broadcast registers.
    always_ff @(posedge clock) begin
        for (int k = 0; k < WAYS; k++) begin
            if (!reset) begin
                lane_q[k] <= '0;
            end else begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    // Round-robin pointer; flush restarts the scan at FU 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (except) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= next_ptr;
        end
    end

    // Flatten lanes onto the output ports.
    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            cdb_valid[k] = lane_q[k].valid;
            cdb_tag[k]   = lane_q[k].tag;
            cdb_value[k] = lane_q[k].value;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vectors, a reference model
// checked every cycle, and a random hold/valid stress run.
module tb_cdb_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic             except;
    logic [7:0]       fu_valid;
    logic [7:0][5:0]  fu_tag;
    logic [7:0][31:0] fu_value;
    logic [7:0]       fu_ready;
    logic [3:0]       cdb_valid;
    logic [3:0][5:0]  cdb_tag;
    logic [3:0][31:0] cdb_value;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0]  m_v;
    logic [5:0]  m_tag [4];
    logic [31:0] m_val [4];
    int          m_ptr;
    int          m_live = 0;
    int          seen [4096];

    cdb_arbiter dut (
        .clock     (clk),
        .reset     (reset),
        .except    (except),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: spec-level scan, checked on every falling edge.
    always @(negedge clk) begin
        logic [7:0] exp_rdy;
        int n;
        int last;
        int i;
        exp_rdy = '0;
        if (m_live != 0) begin
            chk("cdb_valid", 64'(cdb_valid), 64'(m_v));
            for (int k = 0; k < 4; k++) begin
                chk("cdb_tag", 64'(cdb_tag[k]), 64'(m_tag[k]));
                chk("cdb_value", 64'(cdb_value[k]), 64'(m_val[k]));
                if (cdb_valid[k] && cdb_value[k][31:28] == 4'h5)
                    seen[cdb_value[k][11:0]]++;
            end
        end
        if (reset === 1'b0) begin
            m_ptr = 0;
            m_v   = '0;
            for (int k = 0; k < 4; k++) begin
                m_tag[k] = '0;
                m_val[k] = '0;
            end
            chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
            m_live = 1;
        end else if (m_live != 0) begin
            if (except) begin
                m_v   = '0;
                m_ptr = 0;
            end else begin
                n    = 0;
                last = 0;
                for (int s = 0; s < 8; s++) begin
                    i = (m_ptr + s) % 8;
                    if (fu_valid[i] && n < 4) begin
                        exp_rdy[i] = 1'b1;
                        m_tag[n]   = fu_tag[i];
                        m_val[n]   = fu_value[i];
                        last       = i;
                        n++;
                    end
                end
                for (int k = 0; k < 4; k++) m_v[k] = (k < n);
                if (n > 0) m_ptr = (last + 1) % 8;
            end
            chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
        end
    end

    task automatic edge_after;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt [8];
        int lastg [8];
        int max_gap;
        logic [7:0] g;
        logic [7:0] have;
        int next_id;
        int bad;
        int guard;

        for (int k = 0; k < 4096; k++) seen[k] = 0;
        reset    = 1'b0;
        except   = 1'b0;
        fu_valid = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            fu_tag[k]   = 6'(k + 8);
            fu_value[k] = 32'hA000_0000 + 32'(k);
        end

        // 1: reset, then 0-3 and 4-7
        @(negedge clk);
        chk("rst_ready", 64'(fu_ready), 64'h0);
        edge_after();
        chk("rst_valid", 64'(cdb_valid), 64'h0);
        chk("rst_tag", 64'(cdb_tag), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("t1_ready_lo", 64'(fu_ready), 64'h0F);
        edge_after();
        chk("t1_valid", 64'(cdb_valid), 64'hF);
        chk("t1_tag0", 64'(cdb_tag[0]), 64'd8);
        chk("t1_tag3", 64'(cdb_tag[3]), 64'd11);
        @(negedge clk);
        chk("t1_ready_hi", 64'(fu_ready), 64'hF0);
        edge_after();
        chk("t1_tag_hi", 64'(cdb_tag[0]), 64'd12);
        chk("t1_val_hi", 64'(cdb_value[3]), 64'hA000_0007);

        // 3: six cycles all-valid
        for (int k = 0; k < 8; k++) begin
            cnt[k]   = 0;
            lastg[k] = -1;
        end
        max_gap = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t3_alt", 64'(fu_ready), (c % 2 == 0) ? 64'h0F : 64'hF0);
            for (int k = 0; k < 8; k++) begin
                if (fu_ready[k]) begin
                    cnt[k]++;
                    if (c - lastg[k] > max_gap) max_gap = c - lastg[k];
                    lastg[k] = c;
                end
            end
            edge_after();
        end
        for (int k = 0; k < 8; k++) chk("t3_count", 64'(cnt[k]), 64'd3);
        chk("t3_gap", 64'(max_gap <= 2), 64'd1);

        // 2: FU 5 alone
        fu_valid    = 8'h20;
        fu_tag[5]   = 6'd40;
        fu_value[5] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_ready", 64'(fu_ready), 64'h20);
        edge_after();
        chk("t2_valid", 64'(cdb_valid), 64'h1);
        chk("t2_tag", 64'(cdb_tag[0]), 64'd40);
        chk("t2_value", 64'(cdb_value[0]), 64'hDEAD_BEEF);

        // 4: move pointer to 2, then wrap-around scan
        fu_valid = 8'h02;
        @(negedge clk);
        chk("t4_ptr_setup", 64'(fu_ready), 64'h02);
        edge_after();
        fu_valid = 8'h86;
        @(negedge clk);
        chk("t4_ready", 64'(fu_ready), 64'h86);
        edge_after();
        chk("t4_valid", 64'(cdb_valid), 64'h7);
        chk("t4_lane0", 64'(cdb_tag[0]), 64'd10);
        chk("t4_lane1", 64'(cdb_tag[1]), 64'd15);
        chk("t4_lane2", 64'(cdb_tag[2]), 64'd9);
        fu_valid = 8'hFF;
        @(negedge clk);
        chk("t4_ptr", 64'(fu_ready), 64'h3C);
        edge_after();

        // 5: except flush
        except = 1'b1;
        @(negedge clk);
        chk("t5_ready", 64'(fu_ready), 64'h0);
        edge_after();
        chk("t5_valid", 64'(cdb_valid), 64'h0);
        except = 1'b0;
        @(negedge clk);
        chk("t5_restart", 64'(fu_ready), 64'h0F);
        edge_after();

        // 6: reset and except together
        reset  = 1'b0;
        except = 1'b1;
        @(negedge clk);
        chk("t6_ready", 64'(fu_ready), 64'h0);
        edge_after();
        chk("t6_valid", 64'(cdb_valid), 64'h0);
        chk("t6_tag", 64'(cdb_tag), 64'h0);
        chk("t6_value", 64'(cdb_value), 64'h0);
        reset  = 1'b1;
        except = 1'b0;
        @(negedge clk);
        chk("t6_restart", 64'(fu_ready), 64'h0F);
        edge_after();

        // stress: random arrivals, results held until granted
        fu_valid = '0;
        have     = '0;
        next_id  = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            g = fu_valid & fu_ready;
            edge_after();
            for (int k = 0; k < 8; k++) begin
                if (g[k]) have[k] = 1'b0;
                if (!have[k] && $urandom_range(0, 2) != 0) begin
                    have[k]     = 1'b1;
                    fu_tag[k]   = 6'(next_id);
                    fu_value[k] = {4'h5, 16'h0, 12'(next_id)};
                    next_id++;
                end
            end
            fu_valid = have;
        end
        guard = 0;
        while (have != 0 && guard < 30) begin
            @(negedge clk);
            g = fu_valid & fu_ready;
            edge_after();
            have     = have & ~g;
            fu_valid = have;
            guard++;
        end
        chk("stress_drain", 64'(have), 64'h0);
        edge_after();
        edge_after();
        bad = 0;
        for (int k = 0; k < next_id; k++) if (seen[k] != 1) bad++;
        chk("stress_once", 64'(bad), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
